// File: rtl/rv_defs_pkg.sv
// Shared definitions for the execute-stage data-memory responder:
// FSM encodings, lane count and the captured-request record.
package rv_defs;

    localparam int DM_BYTES        = 4;
    localparam int DEF_WAIT_STATES = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } dm_state_e;

    typedef struct packed {
        logic                store;
        logic                oor;
        logic [31:0]         data;
        logic [DM_BYTES-1:0] sel;
    } dm_req_t;

endpackage

// File: rtl/rv_dmem_ram.sv
// Single-port synchronous data RAM, 32-bit words, per-byte write enables,
// one-cycle registered read.
module rv_dmem_ram
    import rv_defs::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic                  re,
    input  logic [DM_BYTES-1:0]   sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [DM_BYTES-1:0][7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int b = 0; b < DM_BYTES; b++) begin
                if (sel[b]) mem[addr][b] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/rv_dmem_responder.sv
// Data-memory responder: captures a load/store, inserts wait states, pulses
// ready, commits into local RAM and returns the aligned load word a cycle later.
module rv_dmem_responder
    import rv_defs::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = DEF_WAIT_STATES,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [31:0]         dm_addr_i,
    input  logic [31:0]         dm_data_s_i,
    input  logic [DM_BYTES-1:0] dm_data_select_i,
    input  logic                dm_store_i,
    input  logic                dm_load_i,
    output logic                dm_ready_o,
    output logic [31:0]         dm_data_l_o,
    output logic                dm_load_done_o,
    output logic                dm_err_o
);

    dm_state_e             state_q, state_d;
    dm_req_t               req_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  req, oor, accept, ack, commit, ram_we, ram_re;
    logic                  load_done_q, err_q;
    logic [31:0]           off, ram_rdata, load_word, hold_q;

    assign req    = dm_load_i | dm_store_i;
    assign off    = dm_addr_i - BASE_ADDR;
    assign oor    = (dm_addr_i < BASE_ADDR) || ((off >> (ADDR_WIDTH + 2)) != 32'd0);
    assign accept = (state_q == ST_IDLE) && req;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req) state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
            ST_WAIT: begin
                if (!req)              state_d = ST_IDLE;
                else if (cnt_q == 4'd1) state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A request dropped in ACK is a flush: no ready, no RAM access.
    always_comb begin
        ack    = (state_q == ST_ACK);
        commit = ack && req;
        ram_we = commit && req_q.store && !req_q.oor;
        ram_re = commit && !req_q.store && !req_q.oor;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= '0;
        end else begin
            if (accept) begin
                req_q <= '{store: dm_store_i, oor: oor,
                           data: dm_data_s_i, sel: dm_data_select_i};
                idx_q <= off[ADDR_WIDTH+1:2];
                cnt_q <= 4'(WAIT_STATES);
                if ((dm_store_i && dm_load_i) || oor) err_q <= 1'b1;
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            load_done_q <= commit && !req_q.store;
            if (load_done_q) hold_q <= load_word;
        end
    end

    rv_dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk_i (clk_i),
        .we    (ram_we),
        .re    (ram_re),
        .sel   (req_q.sel),
        .addr  (ack ? idx_q : '0),
        .wdata (req_q.data),
        .rdata (ram_rdata)
    );

    // req_q is still the completed load during the done cycle (IDLE).
    assign load_word      = req_q.oor ? 32'h0 : ram_rdata;
    assign dm_data_l_o    = load_done_q ? load_word : hold_q;
    assign dm_ready_o     = commit;
    assign dm_load_done_o = load_done_q;
    assign dm_err_o       = err_q;

endmodule
